frog_life_controller: RTL and testbench

Consumer of the collision flag. It registers `o_Has_Collided` from the collision checker and runs the per-life game flow: death freeze and blink, lives countdown, respawn, level-up on reaching the goal row, and game over. It sits between the collision checker and the frog/car movement blocks, and drives their freeze and reposition controls and the HUD counters.

---
 rtl/frogger_pkg.sv | 21 ++
 rtl/frame_timer.sv | 26 ++
 rtl/frog_life_controller.sv | 134 +++++++++++++
 tb/tb_frog_life_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared game constants and state codes for the frogger blocks
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int TILE_SIZE = 32;
  localparam int SPAWN_X   = 304;
  localparam int SPAWN_Y   = 448;
  localparam int GOAL_Y    = 0;

  function automatic logic [3:0] sat_inc_level(input logic [3:0] level, input logic [3:0] max_level);
    return (level >= max_level) ? max_level : level + 4'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - 8-bit frame-tick counter with clear and limit compare
module frame_timer (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Clear,
  input  logic       i_Frame_Tick,
  input  logic [7:0] i_Limit,
  output logic       o_Done
);

  logic [7:0] count;

  // Holding at the limit keeps o_Done stable until the owner clears the timer.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count <= '0;
    end else if (i_Clear) begin
      count <= '0;
    end else if (i_Frame_Tick && !o_Done) begin
      count <= count + 8'd1;
    end
  end

  assign o_Done = (count == i_Limit);

endmodule

// File: rtl/frog_life_controller.sv
// rtl/frog_life_controller.sv - per-life game flow: death, respawn, level-up, game over
module frog_life_controller
  import frogger_pkg::*;
#(
  parameter int c_LIVES        = 3,
  parameter int c_DEATH_FRAMES = 60,
  parameter int c_LEVEL_FRAMES = 30,
  parameter int c_GRACE_FRAMES = 45,
  parameter int c_BLINK_FRAMES = 8,
  parameter int c_GOAL_Y       = GOAL_Y,
  parameter int c_MAX_LEVEL    = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Frame_Tick,
  input  logic       i_Has_Collided,
  input  logic [9:0] i_Frog_Y,
  input  logic       i_Start,
  output logic [2:0] o_State,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic       o_Freeze,
  output logic       o_Frog_Reset,
  output logic       o_Frog_Visible,
  output logic       o_Game_Over
);

  state_t     state;
  logic [7:0] grace;
  logic [7:0] blink_cnt;
  logic       timer_clear;
  logic       timer_done;
  logic [7:0] timer_limit;
  logic       hit;
  logic       at_goal;

  // Timer is held clear outside the counting states, so a tick on the entry edge is dropped.
  assign timer_clear = !(state == ST_DYING || state == ST_LEVEL_UP);
  assign timer_limit = (state == ST_DYING) ? 8'(c_DEATH_FRAMES) : 8'(c_LEVEL_FRAMES);
  assign hit         = i_Has_Collided && (grace == 8'd0);
  assign at_goal     = (i_Frog_Y <= 10'(c_GOAL_Y));
  assign o_State     = state;

  frame_timer u_frame_timer (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Clear      (timer_clear),
    .i_Frame_Tick (i_Frame_Tick),
    .i_Limit      (timer_limit),
    .o_Done       (timer_done)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state          <= ST_IDLE;
      o_Lives        <= 2'(c_LIVES);
      o_Level        <= '0;
      o_Freeze       <= 1'b1;
      o_Frog_Reset   <= 1'b0;
      o_Frog_Visible <= 1'b0;
      o_Game_Over    <= 1'b0;
      grace          <= '0;
      blink_cnt      <= '0;
    end else begin
      o_Frog_Reset <= 1'b0;
      case (state)
        ST_IDLE, ST_GAME_OVER: begin
          if (i_Start) begin
            state          <= ST_PLAYING;
            o_Lives        <= 2'(c_LIVES);
            o_Level        <= '0;
            grace          <= 8'(c_GRACE_FRAMES);
            o_Frog_Reset   <= 1'b1;
            o_Freeze       <= 1'b0;
            o_Frog_Visible <= 1'b1;
            o_Game_Over    <= 1'b0;
          end
        end
        ST_PLAYING: begin
          if (i_Frame_Tick && grace != 8'd0) begin
            grace <= grace - 8'd1;
          end
          if (hit) begin
            state          <= ST_DYING;
            o_Lives        <= (o_Lives == 2'd0) ? 2'd0 : o_Lives - 2'd1;
            o_Freeze       <= 1'b1;
            o_Frog_Visible <= 1'b0;
            blink_cnt      <= '0;
          end else if (at_goal) begin
            state    <= ST_LEVEL_UP;
            o_Freeze <= 1'b1;
          end
        end
        ST_DYING: begin
          if (timer_done) begin
            if (o_Lives == 2'd0) begin
              state          <= ST_GAME_OVER;
              o_Game_Over    <= 1'b1;
              o_Frog_Visible <= 1'b0;
            end else begin
              state          <= ST_PLAYING;
              grace          <= 8'(c_GRACE_FRAMES);
              o_Frog_Reset   <= 1'b1;
              o_Freeze       <= 1'b0;
              o_Frog_Visible <= 1'b1;
            end
          end else if (i_Frame_Tick) begin
            if (blink_cnt == 8'(c_BLINK_FRAMES - 1)) begin
              blink_cnt      <= '0;
              o_Frog_Visible <= ~o_Frog_Visible;
            end else begin
              blink_cnt <= blink_cnt + 8'd1;
            end
          end
        end
        ST_LEVEL_UP: begin
          if (timer_done) begin
            state          <= ST_PLAYING;
            o_Level        <= sat_inc_level(o_Level, 4'(c_MAX_LEVEL));
            grace          <= 8'(c_GRACE_FRAMES);
            o_Frog_Reset   <= 1'b1;
            o_Freeze       <= 1'b0;
            o_Frog_Visible <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          o_Freeze <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frog_life_controller.sv
// tb/tb_frog_life_controller.sv - randomized scenario bench for frog_life_controller
module tb_frog_life_controller;

  localparam int LIVES = 3;
  localparam int DEATH = 60;
  localparam int LEVELF = 30;
  localparam int GRACE = 45;
  localparam int BLINK = 8;
  localparam int MAXLVL = 9;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_Frame_Tick = 1'b0;
  logic       i_Has_Collided = 1'b0;
  logic [9:0] i_Frog_Y = 10'd200;
  logic       i_Start = 1'b0;
  logic [2:0] o_State;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Freeze;
  logic       o_Frog_Reset;
  logic       o_Frog_Visible;
  logic       o_Game_Over;

  int errors = 0;
  int checks = 0;
  int exp_lives;

  frog_life_controller dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_Frame_Tick   (i_Frame_Tick),
    .i_Has_Collided (i_Has_Collided),
    .i_Frog_Y       (i_Frog_Y),
    .i_Start        (i_Start),
    .o_State        (o_State),
    .o_Lives        (o_Lives),
    .o_Level        (o_Level),
    .o_Freeze       (o_Freeze),
    .o_Frog_Reset   (o_Frog_Reset),
    .o_Frog_Visible (o_Frog_Visible),
    .o_Game_Over    (o_Game_Over)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic cyc();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic random_y();
    i_Frog_Y = 10'($urandom_range(479, 1));
  endtask

  task automatic tick_once();
    i_Frame_Tick = 1'b1;
    cyc();
    i_Frame_Tick = 1'b0;
  endtask

  task automatic idle_gap();
    int g;
    g = int'($urandom_range(3, 0));
    for (int k = 0; k < g; k++) cyc();
  endtask

  task automatic hard_reset();
    i_Rst = 1'b1;
    cyc();
    i_Rst = 1'b0;
    cyc();
  endtask

  task automatic start_game();
    i_Start = 1'b1;
    cyc();
    i_Start = 1'b0;
    exp_lives = LIVES;
  endtask

  task automatic burn_grace();
    for (int k = 0; k < GRACE; k++) begin
      random_y();
      tick_once();
      idle_gap();
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    cyc();
    checks++; if (o_State !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_State); end
    checks++; if (o_Lives !== 2'(LIVES)) begin errors++; $display("FAIL reset_lives got=%0d exp=%0d", o_Lives, LIVES); end
    checks++; if (o_Level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", o_Level); end
    checks++; if ({o_Freeze, o_Frog_Reset, o_Frog_Visible, o_Game_Over} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got=%b exp=1000", {o_Freeze, o_Frog_Reset, o_Frog_Visible, o_Game_Over}); end
    i_Rst = 1'b0;
    cyc();
  endtask

  task automatic test_start();
    random_y();
    start_game();
    checks++; if (o_State !== 3'd1) begin errors++; $display("FAIL start_state got=%0d exp=1", o_State); end
    checks++; if (o_Lives !== 2'(LIVES) || o_Level !== 4'd0) begin
      errors++; $display("FAIL start_counters got lives=%0d level=%0d exp lives=%0d level=0", o_Lives, o_Level, LIVES); end
    checks++; if ({o_Frog_Reset, o_Freeze, o_Frog_Visible} !== 3'b101) begin
      errors++; $display("FAIL start_flags got=%b exp=101", {o_Frog_Reset, o_Freeze, o_Frog_Visible}); end
    cyc();
    checks++; if (o_Frog_Reset !== 1'b0) begin errors++; $display("FAIL start_reset_pulse got=%b exp=0", o_Frog_Reset); end
  endtask

  // Kill the frog (grace must already be zero) and step through the whole death freeze.
  task automatic test_death(input bit tick_on_entry);
    i_Has_Collided = 1'b1;
    i_Frame_Tick = tick_on_entry;
    cyc();
    i_Has_Collided = 1'b0;
    i_Frame_Tick = 1'b0;
    exp_lives = (exp_lives == 0) ? 0 : exp_lives - 1;
    checks++; if (o_State !== 3'd2 || o_Lives !== 2'(exp_lives)) begin
      errors++; $display("FAIL death_entry got state=%0d lives=%0d exp state=2 lives=%0d", o_State, o_Lives, exp_lives); end
    checks++; if (o_Frog_Visible !== 1'b0 || o_Freeze !== 1'b1) begin
      errors++; $display("FAIL death_entry_flags got vis=%b frz=%b exp vis=0 frz=1", o_Frog_Visible, o_Freeze); end
    for (int n = 1; n <= DEATH; n++) begin
      if (n == 20) i_Start = 1'b1;
      tick_once();
      i_Start = 1'b0;
      checks++; if (o_State !== 3'd2 || o_Frog_Visible !== 1'(((n / BLINK) % 2))) begin
        errors++; $display("FAIL death_blink tick=%0d got state=%0d vis=%b exp state=2 vis=%0d", n, o_State, o_Frog_Visible, (n / BLINK) % 2); end
      if (n < DEATH) idle_gap();
    end
    cyc();
    if (exp_lives == 0) begin
      checks++; if (o_State !== 3'd4 || o_Game_Over !== 1'b1 || o_Lives !== 2'd0) begin
        errors++; $display("FAIL game_over got state=%0d go=%b lives=%0d exp state=4 go=1 lives=0", o_State, o_Game_Over, o_Lives); end
      checks++; if (o_Frog_Visible !== 1'b0 || o_Freeze !== 1'b1 || o_Frog_Reset !== 1'b0) begin
        errors++; $display("FAIL game_over_flags got vis=%b frz=%b rst=%b exp 0 1 0", o_Frog_Visible, o_Freeze, o_Frog_Reset); end
    end else begin
      checks++; if (o_State !== 3'd1 || o_Frog_Reset !== 1'b1 || o_Frog_Visible !== 1'b1 || o_Freeze !== 1'b0) begin
        errors++; $display("FAIL respawn got state=%0d rst=%b vis=%b frz=%b exp 1 1 1 0", o_State, o_Frog_Reset, o_Frog_Visible, o_Freeze); end
      checks++; if (o_Lives !== 2'(exp_lives)) begin errors++; $display("FAIL respawn_lives got=%0d exp=%0d", o_Lives, exp_lives); end
    end
  endtask

  task automatic test_game_over();
    hard_reset();
    start_game();
    for (int d = 0; d < LIVES; d++) begin
      burn_grace();
      test_death(d == 1);
    end
    i_Start = 1'b1;
    cyc();
    i_Start = 1'b0;
    checks++; if (o_State !== 3'd1 || o_Lives !== 2'(LIVES) || o_Game_Over !== 1'b0) begin
      errors++; $display("FAIL restart got state=%0d lives=%0d go=%b exp 1 %0d 0", o_State, o_Lives, o_Game_Over, LIVES); end
  endtask

  task automatic test_grace_masking();
    hard_reset();
    random_y();
    start_game();
    burn_grace();
    i_Has_Collided = 1'b1;
    cyc();
    exp_lives--;
    for (int n = 1; n <= DEATH; n++) begin
      tick_once();
      if (n < DEATH) idle_gap();
    end
    cyc();
    checks++; if (o_State !== 3'd1) begin errors++; $display("FAIL grace_respawn got=%0d exp=1", o_State); end
    for (int n = 1; n <= GRACE; n++) begin
      random_y();
      tick_once();
      checks++; if (o_State !== 3'd1) begin errors++; $display("FAIL grace_mask tick=%0d got state=%0d exp=1", n, o_State); end
      if (n < GRACE) idle_gap();
    end
    cyc();
    i_Has_Collided = 1'b0;
    exp_lives--;
    checks++; if (o_State !== 3'd2 || o_Lives !== 2'(exp_lives)) begin
      errors++; $display("FAIL grace_expire got state=%0d lives=%0d exp 2 %0d", o_State, o_Lives, exp_lives); end
  endtask

  task automatic test_level_up();
    int exp_level;
    hard_reset();
    random_y();
    start_game();
    for (int lv = 1; lv <= 12; lv++) begin
      i_Frog_Y = 10'd0;
      cyc();
      random_y();
      checks++; if (o_State !== 3'd3 || o_Frog_Visible !== 1'b1 || o_Freeze !== 1'b1) begin
        errors++; $display("FAIL level_entry round=%0d got state=%0d vis=%b frz=%b exp 3 1 1", lv, o_State, o_Frog_Visible, o_Freeze); end
      for (int n = 1; n <= LEVELF; n++) begin
        tick_once();
        if (o_State !== 3'd3) begin
          checks++; errors++; $display("FAIL level_hold round=%0d tick=%0d got state=%0d exp=3", lv, n, o_State);
        end
        if (n < LEVELF) idle_gap();
      end
      cyc();
      exp_level = (lv > MAXLVL) ? MAXLVL : lv;
      checks++; if (o_State !== 3'd1 || o_Level !== 4'(exp_level) || o_Frog_Reset !== 1'b1) begin
        errors++; $display("FAIL level_exit round=%0d got state=%0d level=%0d rst=%b exp 1 %0d 1", lv, o_State, o_Level, o_Frog_Reset, exp_level); end
    end
  endtask

  task automatic test_priority_and_reset();
    hard_reset();
    random_y();
    start_game();
    burn_grace();
    i_Has_Collided = 1'b1;
    i_Frog_Y = 10'd0;
    cyc();
    i_Has_Collided = 1'b0;
    random_y();
    checks++; if (o_State !== 3'd2 || o_Lives !== 2'(LIVES - 1)) begin
      errors++; $display("FAIL priority got state=%0d lives=%0d exp 2 %0d", o_State, o_Lives, LIVES - 1); end
    for (int n = 0; n < 10; n++) begin
      tick_once();
      idle_gap();
    end
    #2;
    i_Rst = 1'b1;
    #1;
    checks++; if (o_State !== 3'd0 || o_Freeze !== 1'b1 || o_Lives !== 2'(LIVES) || o_Frog_Visible !== 1'b0) begin
      errors++; $display("FAIL async_reset got state=%0d frz=%b lives=%0d vis=%b exp 0 1 %0d 0", o_State, o_Freeze, o_Lives, o_Frog_Visible, LIVES); end
    cyc();
    i_Rst = 1'b0;
    cyc();
    checks++; if (o_State !== 3'd0) begin errors++; $display("FAIL idle_after_reset got=%0d exp=0", o_State); end
  endtask

  initial begin
    test_reset();
    test_start();
    burn_grace();
    test_death(1'b1);
    test_game_over();
    test_grace_masking();
    test_level_up();
    test_priority_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
